// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } arb_state_e;

  localparam int STARVE_MAX_DEFAULT = 2;
  localparam int TIMEOUT_DEFAULT    = 255;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access,
// with bounded data-over-fetch starvation and a busy timeout abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ird_i,
  input  logic [31:0] iaddr_i,
  output logic [31:0] irdata_o,
  output logic        ivalid_o,
  input  logic        drd_i,
  input  logic        dwr_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [3:0]  dbe_i,
  output logic [31:0] drdata_o,
  output logic        dvalid_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] BUSY_LAST  = TW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [TW-1:0] busy_cnt_q, busy_cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [31:0]   irdata_q, irdata_d, drdata_q, drdata_d;
  logic          ivalid_q, ivalid_d, dvalid_q, dvalid_d, err_q, err_d;

  logic grant_data, grant_fetch, busy, timeout_hit;

  assign grant_data  = (drd_i | dwr_i) && ((starve_cnt_q < STARVE_LIM) || !ird_i);
  assign grant_fetch = !grant_data && ird_i;
  assign busy        = (state_q != ST_IDLE);
  // An ack in the last allowed busy cycle completes normally instead of aborting.
  assign timeout_hit = busy && !mem_ack_i && (busy_cnt_q == BUSY_LAST);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_data)       state_d = ST_DBUSY;
        else if (grant_fetch) state_d = ST_IBUSY;
      end
      ST_IBUSY, ST_DBUSY: begin
        if (mem_ack_i || timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    busy_cnt_d   = busy_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    ivalid_d     = 1'b0;
    dvalid_d     = 1'b0;
    err_d        = 1'b0;
    if (!busy) begin
      busy_cnt_d = '0;
      if (grant_data) begin
        addr_d  = daddr_i;
        wdata_d = dwdata_i;
        be_d    = dbe_i;
        we_d    = dwr_i;
        if (!ird_i)                         starve_cnt_d = '0;
        else if (starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 1'b1;
      end else if (grant_fetch) begin
        addr_d       = iaddr_i;
        wdata_d      = '0;
        be_d         = 4'hF;
        we_d         = 1'b0;
        starve_cnt_d = '0;
      end
    end else begin
      busy_cnt_d = busy_cnt_q + 1'b1;
      if (mem_ack_i) begin
        if (state_q == ST_IBUSY) begin
          ivalid_d = 1'b1;
          irdata_d = mem_rdata_i;
        end else begin
          dvalid_d = 1'b1;
          if (!we_q) drdata_d = mem_rdata_i;
        end
      end else if (timeout_hit) begin
        err_d = 1'b1;
        if (state_q == ST_IBUSY) begin
          ivalid_d = 1'b1;
          irdata_d = '0;
        end else begin
          dvalid_d = 1'b1;
          drdata_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      starve_cnt_q <= '0;
      busy_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      irdata_q     <= '0;
      drdata_q     <= '0;
      ivalid_q     <= 1'b0;
      dvalid_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_cnt_q   <= busy_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
      ivalid_q     <= ivalid_d;
      dvalid_q     <= dvalid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    mem_req_o   = busy;
    mem_we_o    = we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_be_o    = be_q;
    irdata_o    = irdata_q;
    drdata_o    = drdata_q;
    ivalid_o    = ivalid_q;
    dvalid_o    = dvalid_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/responses, monitors pop and compare.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 255;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ird_i, drd_i, dwr_i;
  logic [31:0] iaddr_i, daddr_i, dwdata_i;
  logic [3:0]  dbe_i;
  logic [31:0] irdata_o, drdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        ivalid_o, dvalid_o, mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [3:0]  mem_be_o;

  mem_port_arbiter #(.STARVE_MAX(2), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ird_i(ird_i), .iaddr_i(iaddr_i), .irdata_o(irdata_o), .ivalid_o(ivalid_o),
    .drd_i(drd_i), .dwr_i(dwr_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i), .dbe_i(dbe_i),
    .drdata_o(drdata_o), .dvalid_o(dvalid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic        chk_wdata;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } plan_t;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];
  plan_t  plan_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int req_cycle = 0;
  logic req_prev = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_g(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic chk, input logic [31:0] wd);
    grant_t g;
    g.addr = a; g.we = we; g.be = be; g.chk_wdata = chk; g.wdata = wd;
    exp_grant.push_back(g);
  endtask

  task automatic exp_r(input logic isd, input logic [31:0] d, input logic e, input int lat);
    resp_t r;
    r.is_data = isd; r.data = d; r.err = e; r.lat = lat;
    exp_resp.push_back(r);
  endtask

  task automatic plan(input int d, input logic [31:0] rd);
    plan_t p;
    p.delay = d; p.rdata = rd;
    plan_q.push_back(p);
  endtask

  // Monitor: grant fields on each mem_req_o rise, response fields on each valid pulse.
  grant_t mg;
  resp_t  mr;
  always @(negedge clk_i) begin
    if (mem_req_o && !req_prev) begin
      req_cycle = cyc;
      if (exp_grant.size() == 0) begin
        check("unexpected_grant", 32'd1, 32'd0);
      end else begin
        mg = exp_grant.pop_front();
        check("grant_addr", mem_addr_o, mg.addr);
        check("grant_we", {31'd0, mem_we_o}, {31'd0, mg.we});
        check("grant_be", {28'd0, mem_be_o}, {28'd0, mg.be});
        if (mg.chk_wdata) check("grant_wdata", mem_wdata_o, mg.wdata);
      end
    end
    req_prev = mem_req_o;
    if (ivalid_o && dvalid_o) check("both_valid", 32'd1, 32'd0);
    if (err_o && !(ivalid_o || dvalid_o)) check("err_without_valid", 32'd1, 32'd0);
    if (ivalid_o || dvalid_o) begin
      if (exp_resp.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mr = exp_resp.pop_front();
        $display("txn %s data=%08h err=%0d lat=%0d", dvalid_o ? "D" : "I",
                 dvalid_o ? drdata_o : irdata_o, err_o, cyc - req_cycle);
        check("resp_kind", {31'd0, dvalid_o}, {31'd0, mr.is_data});
        check("resp_data", dvalid_o ? drdata_o : irdata_o, mr.data);
        check("resp_err", {31'd0, err_o}, {31'd0, mr.err});
        check("resp_latency", cyc - req_cycle, mr.lat);
      end
    end
  end

  // Memory model: ack after the planned delay from mem_req_o, or never if delay < 0.
  plan_t mp;
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        if (plan_q.size() == 0) begin
          check("mem_plan_empty", 32'd1, 32'd0);
        end else begin
          mp = plan_q.pop_front();
          if (mp.delay >= 0) begin
            repeat (mp.delay) @(negedge clk_i);
            mem_ack_i   = 1'b1;
            mem_rdata_i = mp.rdata;
            @(negedge clk_i);
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
          end
        end
        while (mem_req_o) @(negedge clk_i);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
    check({tag, "_addr"}, mem_addr_o, 32'd0);
    check({tag, "_wdata"}, mem_wdata_o, 32'd0);
    check({tag, "_be"}, {28'd0, mem_be_o}, 32'd0);
    check({tag, "_valids_err"}, {29'd0, ivalid_o, dvalid_o, err_o}, 32'd0);
    check({tag, "_irdata"}, irdata_o, 32'd0);
    check({tag, "_drdata"}, drdata_o, 32'd0);
  endtask

  // Waits for n valid pulses; each request drops on its own valid unless hold is set.
  task automatic run(input int n, input bit hold, input int budget, input string name);
    int seen = 0;
    int c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk_i);
      c++;
      if (ivalid_o) begin
        seen++;
        if (!hold) ird_i = 1'b0;
      end
      if (dvalid_o) begin
        seen++;
        if (!hold) begin drd_i = 1'b0; dwr_i = 1'b0; end
      end
    end
    ird_i = 1'b0; drd_i = 1'b0; dwr_i = 1'b0;
    if (seen < n) check({name, "_wait_expired"}, seen, n);
  endtask

  initial begin
    int w;
    reset_i = 1'b1;
    ird_i = 0; drd_i = 0; dwr_i = 0;
    iaddr_i = '0; daddr_i = '0; dwdata_i = '0; dbe_i = '0;
    #2 reset_i = 1'b0;
    #20 check_all_zero("reset");
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Single fetch, ack 3 cycles after mem_req_o
    exp_g(32'h100, 1'b0, 4'hF, 1'b0, '0);
    plan(3, 32'h0000_0013);
    exp_r(1'b0, 32'h0000_0013, 1'b0, 4);
    ird_i = 1; iaddr_i = 32'h100;
    run(1, 0, 50, "fetch");

    // Simultaneous fetch and data read: data first
    exp_g(32'h2000, 1'b0, 4'hF, 1'b0, '0);
    plan(1, 32'hDEAD_BEEF);
    exp_r(1'b1, 32'hDEAD_BEEF, 1'b0, 2);
    exp_g(32'h104, 1'b0, 4'hF, 1'b0, '0);
    plan(2, 32'h0050_0093);
    exp_r(1'b0, 32'h0050_0093, 1'b0, 3);
    @(negedge clk_i);
    ird_i = 1; iaddr_i = 32'h104;
    drd_i = 1; daddr_i = 32'h2000; dbe_i = 4'hF;
    run(2, 0, 50, "both");

    // Write: drdata_o keeps the previous read value
    exp_g(32'h2004, 1'b1, 4'h3, 1'b1, 32'hA5A5_A5A5);
    plan(0, 32'h1111_1111);
    exp_r(1'b1, 32'hDEAD_BEEF, 1'b0, 1);
    @(negedge clk_i);
    dwr_i = 1; daddr_i = 32'h2004; dwdata_i = 32'hA5A5_A5A5; dbe_i = 4'h3;
    run(1, 0, 50, "write");

    // Read and write together resolve as a write
    exp_g(32'h2008, 1'b1, 4'hF, 1'b1, 32'h0BAD_F00D);
    plan(1, 32'h2222_2222);
    exp_r(1'b1, 32'hDEAD_BEEF, 1'b0, 2);
    @(negedge clk_i);
    drd_i = 1; dwr_i = 1; daddr_i = 32'h2008; dwdata_i = 32'h0BAD_F00D; dbe_i = 4'hF;
    run(1, 0, 50, "rdwr");

    // Starvation bound: D,D,I,D,D,I with both requests held
    exp_g(32'h3000, 1'b0, 4'hF, 1'b0, '0); plan(1, 32'hD000_0001); exp_r(1'b1, 32'hD000_0001, 1'b0, 2);
    exp_g(32'h3000, 1'b0, 4'hF, 1'b0, '0); plan(1, 32'hD000_0002); exp_r(1'b1, 32'hD000_0002, 1'b0, 2);
    exp_g(32'h200,  1'b0, 4'hF, 1'b0, '0); plan(1, 32'h1000_0003); exp_r(1'b0, 32'h1000_0003, 1'b0, 2);
    exp_g(32'h3000, 1'b0, 4'hF, 1'b0, '0); plan(1, 32'hD000_0004); exp_r(1'b1, 32'hD000_0004, 1'b0, 2);
    exp_g(32'h3000, 1'b0, 4'hF, 1'b0, '0); plan(1, 32'hD000_0005); exp_r(1'b1, 32'hD000_0005, 1'b0, 2);
    exp_g(32'h200,  1'b0, 4'hF, 1'b0, '0); plan(1, 32'h1000_0006); exp_r(1'b0, 32'h1000_0006, 1'b0, 2);
    @(negedge clk_i);
    ird_i = 1; iaddr_i = 32'h200;
    drd_i = 1; daddr_i = 32'h3000; dbe_i = 4'hF;
    run(6, 1, 100, "starve");

    // Timeout abort on a data read
    exp_g(32'h4000, 1'b0, 4'hF, 1'b0, '0);
    plan(-1, '0);
    exp_r(1'b1, 32'h0, 1'b1, TIMEOUT);
    @(negedge clk_i);
    drd_i = 1; daddr_i = 32'h4000;
    run(1, 0, TIMEOUT + 50, "timeout");

    // Ack in the timeout cycle completes normally
    exp_g(32'h4004, 1'b0, 4'hF, 1'b0, '0);
    plan(TIMEOUT - 1, 32'hCAFE_F00D);
    exp_r(1'b1, 32'hCAFE_F00D, 1'b0, TIMEOUT);
    @(negedge clk_i);
    drd_i = 1; daddr_i = 32'h4004;
    run(1, 0, TIMEOUT + 50, "ack_at_timeout");

    // Reset in the middle of a fetch: no response afterwards
    exp_g(32'h300, 1'b0, 4'hF, 1'b0, '0);
    plan(10, 32'h0000_0099);
    @(negedge clk_i);
    ird_i = 1; iaddr_i = 32'h300;
    w = 0;
    while (!mem_req_o && w < 5) begin @(negedge clk_i); w++; end
    check("midreset_req_seen", {31'd0, mem_req_o}, 32'd1);
    @(negedge clk_i);
    #2 reset_i = 1'b0;
    ird_i = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    repeat (20) @(negedge clk_i);

    // Normal operation resumes after reset
    exp_g(32'h104, 1'b0, 4'hF, 1'b0, '0);
    plan(2, 32'h0000_0077);
    exp_r(1'b0, 32'h0000_0077, 1'b0, 3);
    ird_i = 1; iaddr_i = 32'h104;
    run(1, 0, 50, "post_reset");
    repeat (3) @(negedge clk_i);

    check("pending_grants", exp_grant.size(), 0);
    check("pending_responses", exp_resp.size(), 0);
    check("pending_plans", plan_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Shares one unified memory port between the core's instruction-fetch port and its data port. Uses a req/ack handshake and a 3-state FSM, with starvation and timeout protection.

Interface
REQ-001 Parameter: STARVE_MAX, 2, max consecutive data grants while a fetch is pending.
REQ-002 Parameter: TIMEOUT, 255, busy cycles without mem_ack_i before abort.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 ird_i  in  1  fetch request; held until ivalid_o.
REQ-006 iaddr_i  in  32  fetch address.
REQ-007 irdata_o  out  32  fetched word (registered).
REQ-008 ivalid_o  out  1  one-cycle pulse, fetch complete.
REQ-009 drd_i  in  1  data read request; held until dvalid_o.
REQ-010 dwr_i  in  1  data write request; held until dvalid_o.
REQ-011 daddr_i  in  32  data address.
REQ-012 dwdata_i  in  32  write data.
REQ-013 dbe_i  in  4  write byte enables.
REQ-014 drdata_o  out  32  read data (registered).
REQ-015 dvalid_o  out  1  one-cycle pulse, data access complete.
REQ-016 mem_req_o / mem_we_o  out  1 / 1  memory request, write enable.
REQ-017 mem_addr_o / mem_wdata_o / mem_be_o  out  32 / 32 / 4  latched request fields.
REQ-018 mem_rdata_i / mem_ack_i  in  32 / 1  memory read data, completion strobe.
REQ-019 err_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-020 FSM states SHALL be IDLE, IBUSY and DBUSY, and transactions SHALL never overlap.
REQ-021 Grant in IDLE SHALL follow this priority:
- data pending (drd_i|dwr_i) and (starve_cnt<STARVE_MAX or !ird_i) -> DBUSY;
- else ird_i -> IBUSY;
- else stay IDLE.
REQ-022 On grant, address, wdata, be and we SHALL be latched; mem_* outputs SHALL be driven from the latches, and mem_req_o SHALL be 1 throughout the busy state.
REQ-023 For fetches, mem_we_o SHALL be 0 and mem_be_o SHALL be 4'hF.
REQ-024 When drd_i and dwr_i are both high, the access SHALL be a write.
REQ-025 Latency: request seen in IDLE at cycle N -> mem_req_o at N+1; ack at cycle M>=N+1 -> valid pulse and registered data at M+1, FSM back in IDLE at M+1.
REQ-026 mem_rdata_i SHALL be captured into irdata_o or drdata_o only on ack of a read; drdata_o SHALL be unchanged on writes.
REQ-027 Request inputs SHALL be ignored while busy, and mem_ack_i SHALL be ignored in IDLE.
REQ-028 starve_cnt:
- +1 on each data grant while ird_i=1, saturating at STARVE_MAX;
- cleared on fetch grant;
- cleared on a data grant with ird_i=0.
REQ-029 Busy-cycle counter SHALL clear on entry to a busy state; reaching TIMEOUT without ack SHALL drop mem_req_o, pulse err_o, pulse the owner's valid with data 32'h0, and return to IDLE.
REQ-030 An ack arriving in the timeout cycle SHALL win: normal completion, no err_o.
REQ-031 ivalid_o and dvalid_o SHALL never be high in the same cycle.

Reset
REQ-032 While reset_i=0, all outputs SHALL be 0, the FSM SHALL be IDLE and all counters and latches SHALL be 0, independent of clk_i.
REQ-033 Reset mid-transaction SHALL abandon the transaction, with no valid or err pulse after release.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum and the STARVE_MAX/TIMEOUT defaults.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Fetch: ird_i=1, iaddr 0x100, ack 3 cycles after mem_req_o with rdata 0x00000013 -> mem_addr_o=0x100, we=0, ivalid_o pulse with irdata_o=0x13.
REQ-037 Simultaneous ird_i and drd_i (daddr 0x2000) -> data served first, then fetch; one valid per transaction.
REQ-038 Data held continuously plus ird_i held, STARVE_MAX=2 -> grant order D,D,I,D,D,I.
REQ-039 Write: dwr_i, daddr 0x2004, dwdata 0xA5A5A5A5, dbe 0x3 -> mem_we_o=1, mem_be_o=0x3, dvalid_o pulse, drdata_o unchanged.
REQ-040 No ack for TIMEOUT cycles in DBUSY -> err_o pulse, dvalid_o with 0; ack in that same cycle -> no err_o.
REQ-041 reset_i low during IBUSY -> mem_req_o=0 immediately, no ivalid_o after release.
